operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Issue stage directly upstream of the arithmetic unit.
- Accepts one RV32I OP / OP-IMM instruction per cycle and decodes it.
- Reads rs1/rs2 from an internal 32-entry register file, or substitutes the decoded immediate.
- Drives registered lhs/rhs/operation/metadata with their valid bits; keeps a per-register pending scoreboard cleared by writeback, and stalls on RAW hazards.

Parameters:
- DATA_WIDTH, 32, operand/register width
- REG_COUNT, 32, architectural registers; address width is $clog2(REG_COUNT)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- instr  input  32  instruction word
- instr_valid  input  1  instr present
- instr_ready  output  1  instr accepted when instr_valid && instr_ready
- lhs  output  DATA_WIDTH  rs1 value
- lhs_valid  output  1  lhs valid
- rhs  output  DATA_WIDTH  rs2 value or immediate
- rhs_valid  output  1  rhs valid
- operation  output  3  funct3 (instr[14:12])
- operation_valid  output  1  operation valid
- metadata  output  7  funct7, imm[11:5] for shift-immediates, else 0
- metadata_valid  output  1  metadata valid
- dest  output  5  rd of the issued instruction
- issue_valid  output  1  issue slot occupied
- issue_ready  input  1  downstream consumes slot when issue_valid && issue_ready
- illegal_instr  output  1  one-cycle pulse: accepted instr had an unsupported opcode
- wb_valid  input  1  writeback strobe
- wb_addr  input  5  writeback register
- wb_data  input  DATA_WIDTH  writeback value

Behaviour:
- Reset (async, rst=1): all registers = 0, pending bits = 0, issue_valid = 0, all *_valid = 0, illegal_instr = 0, lhs/rhs/metadata/operation/dest = 0.
- Decode on opcode instr[6:0]:
  - OP (0110011): rhs = reg[rs2], metadata = instr[31:25]; uses rs1 and rs2.
  - OP-IMM (0010011): uses rs1 only.
    - funct3 = 1 or 5: rhs = zero-extended instr[24:20], metadata = instr[31:25].
    - Otherwise: rhs = sign-extended instr[31:20], metadata = 0.
  - Other opcode: illegal. Accepted and not issued; illegal_instr pulses the following cycle; scoreboard is unchanged.
- Operand read:
  - x0 always reads 0.
  - Bypass: if wb_valid && wb_addr == rs && rs != 0, the operand is wb_data.
- Hazard: a used rs (≠0) is pending and not being written back this cycle.
- Handshake: instr_ready = (!issue_valid || issue_ready) && !hazard.
  - instr_ready may depend on instr bits; it never depends on instr_valid.
- Latency and throughput:
  - An accepted legal instr appears on the outputs on the next clk edge, with issue_valid = 1.
  - Throughput is 1/cycle with issue_ready held high.
- Issue slot:
  - Holds stable while issue_valid && !issue_ready.
  - Clears when consumed with no new accept.
- Valid bits: lhs_valid, rhs_valid, operation_valid and metadata_valid all equal issue_valid (hazards are resolved before issue).
- Scoreboard:
  - Accept of a legal instr with rd ≠ 0 sets pending[rd].
  - wb_valid clears pending[wb_addr] and writes reg[wb_addr], unless wb_addr == 0.
  - Same-cycle set and clear of one register: set wins.
  - Writeback to a non-pending register writes data; no error.
- Self-dependency (rd == rs1, not pending): reads the old value, then sets pending.
- Reset mid-operation: the in-flight issue slot and pending bits are discarded immediately.

Decomposition:
- cpu_pkg holds:
  - OPCODE_OP, OPCODE_OP_IMM
  - FUNCT3_SLL = 1, FUNCT3_SR = 5
  - REG_ADDR_WIDTH = 5
- Sub-module register_file:
  - 2 combinational read ports, 1 write port, x0 hardwired zero, write-to-read bypass.
  - Async reset to zero.
- Scoreboard, decode and issue register live in operand_fetch.

Test Plan:
1. Reset, then issue ADDI x1,x0,5 (0x00500093) with issue_ready=1 -> next cycle issue_valid=1, lhs=0, rhs=5, operation=0, metadata=0, dest=1; pending[1]=1.
2. ADD x2,x1,x1 while pending[1], no wb -> instr_ready=0, held. Then wb_valid with x1=5 -> same cycle instr_ready=1; next cycle lhs=rhs=5; pending[1]=0, pending[2]=1.
3. SRAI x3,x4,3 (0x40325193), x4=0xFFFFFFF0 -> rhs=3, metadata=0x20, operation=5. SLTI x3,x4,-1 -> rhs=0xFFFFFFFF, metadata=0.
4. issue_ready=0 for 3 cycles with instr_valid=1 -> outputs stable, instr_ready=0. Release -> the next instr is accepted in the same cycle the slot is consumed.
5. Opcode 0x03 (LOAD) -> accepted, illegal_instr pulses 1 cycle, issue_valid stays 0, no pending bit set. wb to x0 -> x0 still reads 0.
6. Assert rst with issue_valid=1 and pending[5]=1 -> issue_valid=0 and pending cleared immediately. After release, x5 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants for the issue path.
package cpu_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [6:0] {
        OPCODE_OP     = 7'b0110011,
        OPCODE_OP_IMM = 7'b0010011
    } opcode_e;

    localparam logic [2:0] FUNCT3_SLL = 3'd1;
    localparam logic [2:0] FUNCT3_SR  = 3'd5;

    typedef struct packed {
        logic                      legal;
        logic                      use_rs2;
        logic                      shift_imm;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
    } decode_t;

    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d.legal     = (instr[6:0] == OPCODE_OP) || (instr[6:0] == OPCODE_OP_IMM);
        d.use_rs2   = (instr[6:0] == OPCODE_OP);
        d.shift_imm = (instr[6:0] == OPCODE_OP_IMM) &&
                      ((instr[14:12] == FUNCT3_SLL) || (instr[14:12] == FUNCT3_SR));
        d.rd        = instr[11:7];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.funct3    = instr[14:12];
        d.funct7    = instr[31:25];
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_register_file.sv
// Architectural register file: two combinational reads, one write, x0 fixed at zero,
// and same-cycle write data forwarded to the read ports.
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wr_en && wr_addr == rs1_addr) begin
            rs1_data = wr_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wr_en && wr_addr == rs2_addr) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decodes OP/OP-IMM, reads operands, tracks pending writes and holds
// a single registered issue slot for the arithmetic unit.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic [DATA_WIDTH-1:0]     lhs,
    output logic                      lhs_valid,
    output logic [DATA_WIDTH-1:0]     rhs,
    output logic                      rhs_valid,
    output logic [2:0]                operation,
    output logic                      operation_valid,
    output logic [6:0]                metadata,
    output logic                      metadata_valid,
    output logic [4:0]                dest,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic                      illegal_instr,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data
);

    decode_t               dec;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] rhs_sel;
    logic [6:0]            meta_sel;
    logic                  rs1_hz;
    logic                  rs2_hz;
    logic                  hazard;
    logic                  accept;

    logic                  issue_valid_q, issue_valid_d;
    logic [DATA_WIDTH-1:0] lhs_q, lhs_d;
    logic [DATA_WIDTH-1:0] rhs_q, rhs_d;
    logic [2:0]            operation_q, operation_d;
    logic [6:0]            metadata_q, metadata_d;
    logic [4:0]            dest_q, dest_d;
    logic                  illegal_q, illegal_d;
    logic [REG_COUNT-1:0]  pending_q, pending_d;

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (dec.rs1),
        .rs2_addr (dec.rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (wb_valid),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    always_comb begin
        dec = decode(instr);

        // A writeback landing this cycle resolves the hazard because its data is bypassed.
        rs1_hz = (dec.rs1 != '0) && pending_q[dec.rs1] && !(wb_valid && wb_addr == dec.rs1);
        rs2_hz = (dec.rs2 != '0) && pending_q[dec.rs2] && !(wb_valid && wb_addr == dec.rs2);
        hazard = (dec.legal && rs1_hz) || (dec.use_rs2 && rs2_hz);

        instr_ready = (!issue_valid_q || issue_ready) && !hazard;
        accept      = instr_valid && instr_ready;

        if (dec.use_rs2) begin
            rhs_sel  = rs2_val;
            meta_sel = dec.funct7;
        end else if (dec.shift_imm) begin
            rhs_sel  = DATA_WIDTH'(instr[24:20]);
            meta_sel = dec.funct7;
        end else begin
            rhs_sel  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            meta_sel = '0;
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        lhs_d         = lhs_q;
        rhs_d         = rhs_q;
        operation_d   = operation_q;
        metadata_d    = metadata_q;
        dest_d        = dest_q;
        illegal_d     = accept && !dec.legal;
        pending_d     = pending_q;

        if (accept && dec.legal) begin
            issue_valid_d = 1'b1;
            lhs_d         = rs1_val;
            rhs_d         = rhs_sel;
            operation_d   = dec.funct3;
            metadata_d    = meta_sel;
            dest_d        = dec.rd;
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set of the same register takes precedence.
        if (wb_valid && wb_addr != '0) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (accept && dec.legal && dec.rd != '0) begin
            pending_d[dec.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            lhs_q         <= '0;
            rhs_q         <= '0;
            operation_q   <= '0;
            metadata_q    <= '0;
            dest_q        <= '0;
            illegal_q     <= 1'b0;
            pending_q     <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            lhs_q         <= lhs_d;
            rhs_q         <= rhs_d;
            operation_q   <= operation_d;
            metadata_q    <= metadata_d;
            dest_q        <= dest_d;
            illegal_q     <= illegal_d;
            pending_q     <= pending_d;
        end
    end

    assign issue_valid     = issue_valid_q;
    assign lhs             = lhs_q;
    assign rhs             = rhs_q;
    assign operation       = operation_q;
    assign metadata        = metadata_q;
    assign dest            = dest_q;
    assign illegal_instr   = illegal_q;
    assign lhs_valid       = issue_valid_q;
    assign rhs_valid       = issue_valid_q;
    assign operation_valid = issue_valid_q;
    assign metadata_valid  = issue_valid_q;

endmodule
